uranus_mem_arbiter: RTL and testbench
=====================================

// Module: uranus_mem_arbiter
// PURPOSE
//  Shares one single-port synchronous RAM between Uranus's instruction-fetch port and data port.
//  Grants at most one access per cycle, with data-side priority and a starvation guard for fetch.
//  Tracks in-flight reads through a latency pipeline and routes each returned word to its requester.
//  Sits between the Uranus core and the unified RAM in SoC and simulation tops.
// PARAMETERS
//  ADDR_W        32  address width, both ports and RAM
//  DATA_W        32  data width; write-enable has DATA_W/8 bits
//  MEM_LATENCY    1  RAM read latency in cycles, legal 1..4
//  STARVE_LIMIT   4  max consecutive data grants while a fetch waits, legal 1..15
// PORTS
//  clk           in   1       clock, all flops on rising edge
//  rst           in   1       asynchronous, active-high reset
//  inst_req      in   1       fetch read request, held until inst_gnt
//  inst_addr     in   ADDR_W  fetch byte address
//  inst_gnt      out  1       fetch accepted this cycle
//  inst_rvalid   out  1       inst_rdata valid; pulses 1 cycle
//  inst_rdata    out  DATA_W  fetch data; held until next inst_rvalid
//  data_req      in   1       load/store request, held until data_gnt
//  data_we       in   DATA_W/8  byte write enables; 0 means read
//  data_addr     in   ADDR_W  load/store byte address
//  data_wdata    in   DATA_W  store data
//  data_gnt      out  1       data access accepted this cycle
//  data_rvalid   out  1       data_rdata valid; loads only; pulses 1 cycle
//  data_rdata    out  DATA_W  load data; held until next data_rvalid
//  mem_en        out  1       RAM enable
//  mem_we        out  DATA_W/8  RAM byte write enables
//  mem_addr      out  ADDR_W  RAM address
//  mem_wdata     out  DATA_W  RAM write data
//  mem_rdata     in   DATA_W  RAM read data, valid MEM_LATENCY cycles after a read enable
// BEHAVIOUR
//  Reset: one clock; reset is asynchronous and active-high.
//   - While rst is high, all outputs are 0, including the rdata hold registers.
//   - Tag pipeline and starve counter are cleared.
//   - Reads in flight when rst asserts are discarded; no rvalid for them after release.
//  Arbitration (combinational, same cycle):
//   - Data wins when data_req is set, unless starve_cnt == STARVE_LIMIT and inst_req is set; then inst wins.
//   - At most one of inst_gnt / data_gnt is high per cycle; gnt implies the matching req.
//   - On grant, mem_en=1 and mem_* carry the winner's fields; inst grant drives mem_we=0.
//   - With no grant, mem_en=0, mem_we=0, and addr/wdata are don't-care (drive 0).
//  Starvation counter (4 bits):
//   - Increments on a data grant while inst_req is high.
//   - Clears on any inst grant, or in any cycle where inst_req is low.
//   - Saturates at STARVE_LIMIT.
//  Read tracking:
//   - Shift register of MEM_LATENCY 2-bit tags {valid, owner}.
//   - A read grant (inst, or data with data_we==0) pushes valid=1 with owner 0=inst / 1=data.
//   - Writes and idle cycles push valid=0.
//   - When the tag exits with valid=1, mem_rdata is captured into the owner's hold register.
//   - That owner's rvalid pulses in the same cycle as mem_rdata is sampled.
//   - For MEM_LATENCY=1, the response arrives the cycle after the grant.
//  Throughput and ordering:
//   - Fully pipelined: one grant per cycle, back-to-back reads from either port.
//   - Responses return in grant order; no reordering, no combinational path from mem_rdata to rvalid.
//  Boundary conditions:
//   - Write granted while reads are in flight: allowed; a write never produces rvalid.
//   - Requester drops req without a grant: legal; nothing is issued.
//   - Addresses pass through unaligned; alignment is the core's responsibility.
// TESTING
//  1. Reset: rst=1 with both req=1 -> all outputs 0; rst=0 -> first grant in the same cycle as release.
//  2. Fetch only: inst_req=1 for addrs 0x0,0x4,0x8 with MEM_LATENCY=1 -> inst_gnt 3 cycles,
//     then inst_rvalid 3 consecutive cycles with the RAM words in order.
//  3. Contention: both req held continuously, STARVE_LIMIT=4 -> data_gnt x4, inst_gnt x1, repeating; never both high.
//  4. Mixed traffic: store 0xDEADBEEF to 0x100 (we=4'hF), then load 0x100 -> data_rvalid with 0xDEADBEEF;
//     the store produces no rvalid. Repeat with we=4'h1 and byte 0xAA -> 0xDEADBEAA.
//  5. Latency sweep: MEM_LATENCY=3, alternating inst/data reads -> each rvalid exactly 3 cycles after its gnt,
//     routed to the correct owner.
//  6. Mid-flight reset: rst pulsed 1 cycle after a data read grant -> no data_rvalid ever; data_rdata stays 0.

Source files
------------

// File: rtl/uranus_mem_arbiter.sv
// Uranus fetch/data arbiter for one single-port synchronous RAM: data-side priority with a fetch
// starvation guard, and a tag pipeline matched to the RAM latency that routes each read word home.
`timescale 1ns/1ps
module uranus_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_gnt,
  output logic                inst_rvalid,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_we,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_gnt,
  output logic                data_rvalid,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0]             starve_cnt;
  logic                   starved;
  logic                   data_win;
  logic                   inst_win;
  logic                   rd_grant;
  logic [MEM_LATENCY-1:0] vld_p;
  logic [MEM_LATENCY-1:0] own_p;
  logic [MEM_LATENCY-1:0] vld_nxt;
  logic [MEM_LATENCY-1:0] own_nxt;
  logic [DATA_W-1:0]      inst_hold;
  logic [DATA_W-1:0]      data_hold;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == STARVE_MAX) ? v : v + 4'd1;
  endfunction

  // Grant decision: combinational, gated off entirely while reset is held.
  assign starved  = (starve_cnt == STARVE_MAX) && inst_req;
  assign data_win = !rst && data_req && !starved;
  assign inst_win = !rst && inst_req && !data_win;
  assign rd_grant = inst_win || (data_win && (data_we == '0));
  assign inst_gnt = inst_win;
  assign data_gnt = data_win;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (data_win) begin
      mem_en    = 1'b1;
      mem_we    = data_we;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else if (inst_win) begin
      mem_en    = 1'b1;
      mem_addr  = inst_addr;
    end
  end

  // Counts data grants that overtook a waiting fetch; any gap in inst_req forgives the debt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!inst_req || inst_win) begin
      starve_cnt <= '0;
    end else if (data_win) begin
      starve_cnt <= sat_inc(starve_cnt);
    end
  end

  // Stage p0 takes the tag of this cycle's grant; the last stage lines up with mem_rdata.
  generate
    if (MEM_LATENCY == 1) begin : g_lat1
      assign vld_nxt = rd_grant;
      assign own_nxt = data_win;
    end else begin : g_latn
      assign vld_nxt = {vld_p[MEM_LATENCY-2:0], rd_grant};
      assign own_nxt = {own_p[MEM_LATENCY-2:0], data_win};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
      own_p <= '0;
    end else begin
      vld_p <= vld_nxt;
      own_p <= own_nxt;
    end
  end

  assign inst_rvalid = vld_p[MEM_LATENCY-1] && !own_p[MEM_LATENCY-1];
  assign data_rvalid = vld_p[MEM_LATENCY-1] &&  own_p[MEM_LATENCY-1];

  // Hold registers keep the last word per owner once the response cycle has passed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_hold <= '0;
      data_hold <= '0;
    end else begin
      if (inst_rvalid) inst_hold <= mem_rdata;
      if (data_rvalid) data_hold <= mem_rdata;
    end
  end

  assign inst_rdata = inst_rvalid ? mem_rdata : inst_hold;
  assign data_rdata = data_rvalid ? mem_rdata : data_hold;

endmodule

// File: tb/tb_uranus_mem_arbiter.sv
// Bench for uranus_mem_arbiter: two instances (latency 1 and 3) share stimulus, each with its own RAM model.
`timescale 1ns/1ps
module tb_uranus_mem_arbiter;
  localparam int SL = 4;

  typedef struct {
    int          due;
    logic        own;
    logic [31:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        data_req = 1'b0;
  logic [3:0]  data_we = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;

  logic        ig1, irv1, dg1, drv1, men1;
  logic [31:0] ird1, drd1, maddr1, mwd1, mrd1;
  logic [3:0]  mwe1;
  logic        ig3, irv3, dg3, drv3, men3;
  logic [31:0] ird3, drd3, maddr3, mwd3, mrd3;
  logic [3:0]  mwe3;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0]  ram1 [256];
  logic [31:0]  ram3 [256];
  logic [255:0] wr1 = '0;
  logic [255:0] wr3 = '0;
  logic [31:0]  sh [256];
  logic [31:0]  rp1;
  logic [31:0]  rp3 [3];

  uranus_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(SL)) u_dut1 (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(ig1), .inst_rvalid(irv1), .inst_rdata(ird1),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(dg1), .data_rvalid(drv1), .data_rdata(drd1),
    .mem_en(men1), .mem_we(mwe1), .mem_addr(maddr1), .mem_wdata(mwd1), .mem_rdata(mrd1)
  );

  uranus_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .STARVE_LIMIT(SL)) u_dut3 (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(ig3), .inst_rvalid(irv3), .inst_rdata(ird3),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(dg3), .data_rvalid(drv3), .data_rdata(drd3),
    .mem_en(men3), .mem_we(mwe3), .mem_addr(maddr3), .mem_wdata(mwd3), .mem_rdata(mrd3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int w);
    logic [31:0] x;
    x = 32'(w);
    return (x * 32'h9E3779B1) ^ 32'h13572468;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // RAM models: unwritten words read as init_word(index); read data appears after the latency.
  always @(posedge clk) begin
    if (men1) begin
      if (mwe1 != 4'd0) begin
        ram1[maddr1[9:2]] <= merge(wr1[maddr1[9:2]] ? ram1[maddr1[9:2]] : init_word(int'(maddr1[9:2])), mwd1, mwe1);
        wr1[maddr1[9:2]]  <= 1'b1;
      end else begin
        rp1 <= wr1[maddr1[9:2]] ? ram1[maddr1[9:2]] : init_word(int'(maddr1[9:2]));
      end
    end
  end
  assign mrd1 = rp1;

  always @(posedge clk) begin
    if (men3) begin
      if (mwe3 != 4'd0) begin
        ram3[maddr3[9:2]] <= merge(wr3[maddr3[9:2]] ? ram3[maddr3[9:2]] : init_word(int'(maddr3[9:2])), mwd3, mwe3);
        wr3[maddr3[9:2]]  <= 1'b1;
      end else begin
        rp3[0] <= wr3[maddr3[9:2]] ? ram3[maddr3[9:2]] : init_word(int'(maddr3[9:2]));
      end
    end
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end
  assign mrd3 = rp3[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    inst_req = 1'b0;
    data_req = 1'b0;
    data_we  = 4'd0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; inst_req = 1'b1; data_req = 1'b1; data_we = 4'd0;
    inst_addr = 32'h40; data_addr = 32'h80; data_wdata = 32'h1234_5678;
    tick();
    @(negedge clk);
    checks++;
    if ({ig1, dg1, ig3, dg3} !== 4'b0) begin
      failures++; $display("FAIL reset_gnt got=%b exp=0000", {ig1, dg1, ig3, dg3});
    end
    checks++;
    if ({men1, mwe1, men3, mwe3} !== 10'd0) begin
      failures++; $display("FAIL reset_mem_ctl got=%b exp=0", {men1, mwe1, men3, mwe3});
    end
    checks++;
    if ({maddr1, mwd1, maddr3, mwd3} !== 128'd0) begin
      failures++; $display("FAIL reset_mem_bus got=%h %h %h %h exp=0", maddr1, mwd1, maddr3, mwd3);
    end
    checks++;
    if ({irv1, drv1, irv3, drv3} !== 4'b0) begin
      failures++; $display("FAIL reset_rvalid got=%b exp=0000", {irv1, drv1, irv3, drv3});
    end
    checks++;
    if ({ird1, drd1, ird3, drd3} !== 128'd0) begin
      failures++; $display("FAIL reset_rdata got=%h %h %h %h exp=0", ird1, drd1, ird3, drd3);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({ig1, dg1, ig3, dg3} !== 4'b0101) begin
      failures++; $display("FAIL release_gnt got=%b exp=0101", {ig1, dg1, ig3, dg3});
    end
    checks++;
    if (men1 !== 1'b1 || maddr1 !== 32'h80 || mwe1 !== 4'd0) begin
      failures++; $display("FAIL release_mem got=en%b a%h we%h exp=en1 a00000080 we0", men1, maddr1, mwe1);
    end
    tick();
  endtask

  task automatic test_fetch_only();
    idle(2);
    inst_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      inst_addr = 32'(4 * k);
      @(negedge clk);
      checks++;
      if (ig1 !== 1'b1 || dg1 !== 1'b0 || maddr1 !== 32'(4 * k) || men1 !== 1'b1) begin
        failures++; $display("FAIL fetch_gnt%0d got=g%b a%h exp=g1 a%h", k, ig1, maddr1, 32'(4 * k));
      end
      if (k > 0) begin
        checks++;
        if (irv1 !== 1'b1 || ird1 !== init_word(k - 1)) begin
          failures++; $display("FAIL fetch_rsp%0d got=v%b d%h exp=v1 d%h", k - 1, irv1, ird1, init_word(k - 1));
        end
      end
      tick();
    end
    inst_req = 1'b0;
    @(negedge clk);
    checks++;
    if (irv1 !== 1'b1 || ird1 !== init_word(2) || ig1 !== 1'b0) begin
      failures++; $display("FAIL fetch_rsp2 got=v%b d%h g%b exp=v1 d%h g0", irv1, ird1, ig1, init_word(2));
    end
    tick();
    @(negedge clk);
    checks++;
    if (irv1 !== 1'b0 || ird1 !== init_word(2)) begin
      failures++; $display("FAIL fetch_hold got=v%b d%h exp=v0 d%h", irv1, ird1, init_word(2));
    end
    tick();
  endtask

  task automatic test_contention();
    idle(1);
    inst_req = 1'b1; data_req = 1'b1; data_we = 4'd0;
    inst_addr = 32'h10; data_addr = 32'h20;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      checks++;
      if ({ig1, dg1} !== {(k % 5 == 4), (k % 5 != 4)} || {ig3, dg3} !== {ig1, dg1}) begin
        failures++; $display("FAIL contention%0d got=%b%b/%b%b exp=%b%b", k, ig1, dg1, ig3, dg3,
                             (k % 5 == 4), (k % 5 != 4));
      end
      tick();
    end
  endtask

  task automatic test_mixed();
    logic [31:0] exp_word [2];
    logic [3:0]  we_v [2];
    logic [31:0] wd_v [2];
    exp_word[0] = 32'hDEADBEEF; we_v[0] = 4'hF; wd_v[0] = 32'hDEADBEEF;
    exp_word[1] = 32'hDEADBEAA; we_v[1] = 4'h1; wd_v[1] = 32'h000000AA;
    idle(2);
    for (int r = 0; r < 2; r++) begin
      data_req = 1'b1; data_we = we_v[r]; data_addr = 32'h100; data_wdata = wd_v[r];
      @(negedge clk);
      checks++;
      if (dg1 !== 1'b1 || men1 !== 1'b1 || mwe1 !== we_v[r] || maddr1 !== 32'h100 || mwd1 !== wd_v[r]) begin
        failures++; $display("FAIL store%0d got=g%b we%h a%h d%h exp=g1 we%h a00000100 d%h", r, dg1, mwe1,
                             maddr1, mwd1, we_v[r], wd_v[r]);
      end
      tick();
      data_we = 4'd0;
      @(negedge clk);
      checks++;
      if (dg1 !== 1'b1 || drv1 !== 1'b0 || irv1 !== 1'b0) begin
        failures++; $display("FAIL store_norsp%0d got=g%b dv%b iv%b exp=g1 dv0 iv0", r, dg1, drv1, irv1);
      end
      tick();
      data_req = 1'b0;
      @(negedge clk);
      checks++;
      if (drv1 !== 1'b1 || drd1 !== exp_word[r]) begin
        failures++; $display("FAIL load%0d got=v%b d%h exp=v1 d%h", r, drv1, drd1, exp_word[r]);
      end
      tick();
    end
  endtask

  task automatic test_latency();
    logic        e_i [10];
    logic        e_d [10];
    logic [31:0] e_dat [10];
    for (int k = 0; k < 10; k++) begin e_i[k] = 1'b0; e_d[k] = 1'b0; e_dat[k] = '0; end
    idle(4);
    for (int k = 0; k < 10; k++) begin
      if (k < 6) begin
        inst_req = (k % 2 == 0); data_req = (k % 2 == 1); data_we = 4'd0;
        inst_addr = 32'h200 + 32'(4 * k); data_addr = 32'h300 + 32'(4 * k);
      end else begin
        inst_req = 1'b0; data_req = 1'b0;
      end
      @(negedge clk);
      if (k < 6) begin
        checks++;
        if (ig3 !== (k % 2 == 0) || dg3 !== (k % 2 == 1)) begin
          failures++; $display("FAIL lat_gnt%0d got=%b%b exp=%b%b", k, ig3, dg3, (k % 2 == 0), (k % 2 == 1));
        end
        e_i[k + 3] = (k % 2 == 0);
        e_d[k + 3] = (k % 2 == 1);
        e_dat[k + 3] = (k % 2 == 0) ? init_word(32'h80 + k) : init_word(32'hC0 + k);
      end
      checks++;
      if (irv3 !== e_i[k] || drv3 !== e_d[k]) begin
        failures++; $display("FAIL lat_rvalid%0d got=%b%b exp=%b%b", k, irv3, drv3, e_i[k], e_d[k]);
      end
      if (e_i[k]) begin
        checks++;
        if (ird3 !== e_dat[k]) begin
          failures++; $display("FAIL lat_idata%0d got=%h exp=%h", k, ird3, e_dat[k]);
        end
      end
      if (e_d[k]) begin
        checks++;
        if (drd3 !== e_dat[k]) begin
          failures++; $display("FAIL lat_ddata%0d got=%h exp=%h", k, drd3, e_dat[k]);
        end
      end
      tick();
    end
  endtask

  task automatic test_midflight_reset();
    idle(4);
    data_req = 1'b1; data_we = 4'd0; data_addr = 32'h104;
    @(negedge clk);
    checks++;
    if (dg1 !== 1'b1 || dg3 !== 1'b1) begin
      failures++; $display("FAIL mid_gnt got=%b%b exp=11", dg1, dg3);
    end
    tick();
    rst = 1'b1; data_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({drv1, drv3} !== 2'b00 || {drd1, drd3} !== 64'd0) begin
      failures++; $display("FAIL mid_in_rst got=v%b%b d%h %h exp=v00 d0", drv1, drv3, drd1, drd3);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if ({drv1, drv3, irv1, irv3} !== 4'b0 || {drd1, drd3} !== 64'd0) begin
        failures++; $display("FAIL mid_after%0d got=v%b%b%b%b d%h %h exp=v0000 d0", k, drv1, drv3, irv1, irv3,
                             drd1, drd3);
      end
      tick();
    end
  endtask

  task automatic test_random();
    resp_t       q1 [$];
    resp_t       q3 [$];
    resp_t       r;
    logic [3:0]  mst = 4'd0;
    logic [31:0] hi1 = '0, hd1 = '0, hi3 = '0, hd3 = '0;
    logic        iwin, dwin, e_iv1, e_dv1, e_iv3, e_dv3;
    logic [31:0] eaddr, ewd;
    logic [3:0]  ewe;
    inst_req = 1'b0; data_req = 1'b0; data_we = 4'd0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) sh[i] = wr1[i] ? ram1[i] : init_word(i);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      dwin  = data_req && !((mst == 4'(SL)) && inst_req);
      iwin  = inst_req && !dwin;
      eaddr = dwin ? data_addr : (iwin ? inst_addr : 32'd0);
      ewe   = dwin ? data_we : 4'd0;
      ewd   = dwin ? data_wdata : 32'd0;
      checks++;
      if ({ig1, dg1} !== {iwin, dwin} || {ig3, dg3} !== {iwin, dwin}) begin
        failures++; $display("FAIL rnd_gnt%0d got=%b%b/%b%b exp=%b%b", n, ig1, dg1, ig3, dg3, iwin, dwin);
      end
      checks++;
      if ({men1, mwe1, maddr1, mwd1} !== {iwin | dwin, ewe, eaddr, ewd} ||
          {men3, mwe3, maddr3, mwd3} !== {iwin | dwin, ewe, eaddr, ewd}) begin
        failures++; $display("FAIL rnd_mem%0d got=en%b we%h a%h d%h exp=en%b we%h a%h d%h", n, men1, mwe1,
                             maddr1, mwd1, iwin | dwin, ewe, eaddr, ewd);
      end
      e_iv1 = 1'b0; e_dv1 = 1'b0; e_iv3 = 1'b0; e_dv3 = 1'b0;
      if (q1.size() > 0 && q1[0].due == cyc) begin
        r = q1.pop_front();
        if (r.own) begin e_dv1 = 1'b1; hd1 = r.data; end else begin e_iv1 = 1'b1; hi1 = r.data; end
      end
      if (q3.size() > 0 && q3[0].due == cyc) begin
        r = q3.pop_front();
        if (r.own) begin e_dv3 = 1'b1; hd3 = r.data; end else begin e_iv3 = 1'b1; hi3 = r.data; end
      end
      checks++;
      if ({irv1, drv1, irv3, drv3} !== {e_iv1, e_dv1, e_iv3, e_dv3}) begin
        failures++; $display("FAIL rnd_rvalid%0d got=%b%b%b%b exp=%b%b%b%b", n, irv1, drv1, irv3, drv3,
                             e_iv1, e_dv1, e_iv3, e_dv3);
      end
      checks++;
      if (ird1 !== hi1 || drd1 !== hd1 || ird3 !== hi3 || drd3 !== hd3) begin
        failures++; $display("FAIL rnd_rdata%0d got=%h %h %h %h exp=%h %h %h %h", n, ird1, drd1, ird3, drd3,
                             hi1, hd1, hi3, hd3);
      end
      if (dwin && data_we != 4'd0) begin
        sh[eaddr[9:2]] = merge(sh[eaddr[9:2]], data_wdata, data_we);
      end else if (iwin || dwin) begin
        r.own = dwin; r.data = sh[eaddr[9:2]];
        r.due = cyc + 1; q1.push_back(r);
        r.due = cyc + 3; q3.push_back(r);
      end
      if (!inst_req || iwin) mst = 4'd0;
      else if (dwin && mst != 4'(SL)) mst = mst + 4'd1;
      tick();
      if (!inst_req || iwin || $urandom_range(15) == 0) begin
        inst_req  = ($urandom_range(2) != 0);
        inst_addr = {22'd0, 10'($urandom)};
      end
      if (!data_req || dwin || $urandom_range(15) == 0) begin
        data_req   = ($urandom_range(2) != 0);
        data_addr  = {22'd0, 10'($urandom)};
        data_we    = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(15, 1));
        data_wdata = $urandom;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fetch_only();
    test_contention();
    test_mixed();
    test_latency();
    test_midflight_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
